jtframe_fraccen_bank: RTL and testbench
=======================================

JTFRAME_FRACCEN_BANK -- requirements
Module: jtframe_fraccen_bank

Interface
REQ-001 Parameter CH, default 4: number of clock-enable channels, range 1..16.
REQ-002 Parameter W, default 10: width of per-channel numerator, denominator and accumulator.
REQ-003 Parameter LOCKDLY, default 16: cycles from reset release or last config write to lock, range 1..255.
REQ-004 Parameter DEF_N, default {CH{W'd1}}: packed CH*W reset numerators, channel 0 in LSBs.
REQ-005 Parameter DEF_M, default {CH{W'd2}}: packed CH*W reset denominators, channel 0 in LSBs.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 cfg_we  input  1  config write strobe, one cycle per write.
REQ-009 cfg_ch  input  clog2(CH) (min 1)  target channel of the write.
REQ-010 cfg_n  input  W  new numerator.
REQ-011 cfg_m  input  W  new denominator.
REQ-012 cen  output  CH  per-channel clock-enable pulses, one clk wide.
REQ-013 err  output  CH  per-channel invalid-ratio flag.
REQ-014 locked  output  1  high when all enables are valid, like a PLL lock.

Function
REQ-015 Each channel shall hold n, m and accumulator acc, all W bits.
REQ-016 Each cycle, for a valid channel: nx = acc + n in W+1 bits; if nx >= m then acc <= nx - m and the channel pulse is 1, else acc <= nx and the pulse is 0.
REQ-017 Long-run pulse rate shall equal exactly n/m of clk, with no cumulative drift.
REQ-018 A channel is invalid when n == 0, m == 0 or n > m; err[i] shall equal that condition, registered.
REQ-019 An invalid channel's acc shall hold at 0 and it shall never pulse.
REQ-020 cen[i] shall be registered: the pulse from the cycle-t accumulator update appears on cen[i] in cycle t+1.
REQ-021 cen[i] shall be forced to 0 whenever locked is 0; accumulators keep running while unlocked.
REQ-022 A write with cfg_we = 1 and cfg_ch < CH shall load n and m of that channel and clear its acc at the same edge.
REQ-023 A write with cfg_ch >= CH shall be ignored entirely, with no effect on lock.
REQ-024 Lock counter: cleared on reset and on every accepted write; increments while below LOCKDLY; saturates at LOCKDLY.
REQ-025 locked = (lock counter == LOCKDLY), registered.
REQ-026 locked shall fall on the cycle after an accepted write.
REQ-027 Back-to-back writes shall each apply in order; the lock delay restarts from the last write.
REQ-028 When n == m, the channel shall pulse every cycle once locked.
REQ-029 Accumulator arithmetic shall never overflow W bits because acc < m always holds.

Reset
REQ-030 With rst_n low: cen = 0, err = DEF-derived validity, locked = 0, lock counter = 0, all acc = 0, n/m = DEF_N/DEF_M.
REQ-031 Reset assertion mid-operation shall clear all state asynchronously within the same cycle.
REQ-032 rst_n deassertion shall be synchronised internally with a 2-flop synchroniser before releasing the state.

Structure
REQ-033 Shared package jtframe_cen_pkg shall hold the maximum channel count (16), the maximum LOCKDLY (255) and the default W (10).
REQ-034 One sub-module, jtframe_fraccen_ch, shall implement a single channel: n/m/acc registers, the valid check, the pulse and the load/clear port.
REQ-035 The top shall instantiate CH copies of jtframe_fraccen_ch plus the lock counter, write decode and cen gating.

Verification
REQ-036 Defaults, release reset, run 100 cycles -> locked rises exactly LOCKDLY cycles after the synchronised release; cen[0] then toggles every other cycle; err = 0.
REQ-037 Write ch1 n=3, m=8, wait for lock, count over 64 cycles -> exactly 24 pulses on cen[1], pattern periodic every 8 cycles.
REQ-038 Write ch2 n=5, m=4 -> err[2] = 1, cen[2] never pulses; rewrite n=4, m=4 -> err[2] = 0 and cen[2] is high every cycle after lock.
REQ-039 Writes on cycles 0, 3 and 10 with LOCKDLY=16 -> locked low from cycle 1, high again at cycle 10+16+1; no cen pulse while low.
REQ-040 With CH=3, write cfg_ch=3 -> no state change and locked stays high.
REQ-041 Pull rst_n low mid-run for 1 cycle -> cen and locked drop immediately; after release the full default behaviour of REQ-036 repeats.

Source files
------------

// File: rtl/jtframe_cen_pkg.sv
// Shared limits and defaults for the fractional clock-enable bank.
package jtframe_cen_pkg;

  localparam int unsigned CEN_MAX_CH      = 16;
  localparam int unsigned CEN_MAX_LOCKDLY = 255;
  localparam int unsigned CEN_DEF_W       = 10;
  localparam int unsigned CEN_LOCK_W      = $clog2(CEN_MAX_LOCKDLY + 1);

  // Channel-select width: one bit minimum so a single-channel bank still has a port.
  function automatic int unsigned cen_sel_w(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/jtframe_fraccen_ch.sv
// One fractional clock-enable channel: n/m ratio registers, phase accumulator,
// validity flag and an unregistered pulse for the bank to gate and register.
module jtframe_fraccen_ch
  import jtframe_cen_pkg::*;
#(
  parameter int unsigned   W     = CEN_DEF_W,
  parameter logic [W-1:0]  DEF_N = W'(1),
  parameter logic [W-1:0]  DEF_M = W'(2)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         load,
  input  logic [W-1:0] ld_n,
  input  logic [W-1:0] ld_m,
  output logic         pulse_c,
  output logic         err
);

  function automatic logic ratio_bad(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a == '0) || (b == '0) || (a > b);
  endfunction

  logic [W-1:0] n;
  logic [W-1:0] m;
  logic [W-1:0] acc;
  logic [W-1:0] n_nx;
  logic [W-1:0] m_nx;
  logic [W-1:0] acc_nx;
  logic [W:0]   sum;
  logic         valid;

  // acc < m always, so acc + n <= 2m - 1 fits in W+1 bits and the difference fits in W.
  always_comb begin
    n_nx    = n;
    m_nx    = m;
    acc_nx  = acc;
    pulse_c = 1'b0;
    valid   = !ratio_bad(n, m);
    sum     = {1'b0, acc} + {1'b0, n};
    if (load) begin
      n_nx   = ld_n;
      m_nx   = ld_m;
      acc_nx = '0;
    end else if (!valid) begin
      acc_nx = '0;
    end else if (run) begin
      if (sum >= {1'b0, m}) begin
        acc_nx  = W'(sum - {1'b0, m});
        pulse_c = 1'b1;
      end else begin
        acc_nx = W'(sum);
      end
    end
  end

  // err tracks the ratio that will be held after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n   <= DEF_N;
      m   <= DEF_M;
      acc <= '0;
      err <= ratio_bad(DEF_N, DEF_M);
    end else begin
      n   <= n_nx;
      m   <= m_nx;
      acc <= acc_nx;
      err <= ratio_bad(n_nx, m_nx);
    end
  end

endmodule

// File: rtl/jtframe_fraccen_bank.sv
// Bank of CH fractional clock enables with a shared config port and a PLL-like
// lock indicator that masks all enables until the ratios have settled.
module jtframe_fraccen_bank
  import jtframe_cen_pkg::*;
#(
  parameter int unsigned      CH      = 4,
  parameter int unsigned      W       = CEN_DEF_W,
  parameter int unsigned      LOCKDLY = 16,
  parameter logic [CH*W-1:0]  DEF_N   = {CH{W'(1)}},
  parameter logic [CH*W-1:0]  DEF_M   = {CH{W'(2)}},
  localparam int unsigned     SELW    = cen_sel_w(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [SELW-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_n,
  input  logic [W-1:0]    cfg_m,
  output logic [CH-1:0]   cen,
  output logic [CH-1:0]   err,
  output logic            locked
);

  localparam int unsigned    LCW      = CEN_LOCK_W;
  localparam logic [LCW-1:0] LOCK_END = LCW'(LOCKDLY);

  if (CH < 1 || CH > CEN_MAX_CH) begin : g_bad_ch
    $error("jtframe_fraccen_bank: CH out of range");
  end
  if (LOCKDLY < 1 || LOCKDLY > CEN_MAX_LOCKDLY) begin : g_bad_lock
    $error("jtframe_fraccen_bank: LOCKDLY out of range");
  end

  logic [1:0]     rst_sync;
  logic           run;
  logic           accept;
  logic [CH-1:0]  load;
  logic [CH-1:0]  pulse;
  logic [LCW-1:0] cnt;
  logic [LCW-1:0] cnt_nx;
  logic           lock_nx;

  // Reset asserts asynchronously; release reaches the datapath two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run    = rst_sync[1];
  assign accept = cfg_we && run && (32'(cfg_ch) < CH);

  always_comb begin
    load = '0;
    for (int i = 0; i < CH; i++) begin
      load[i] = accept && (32'(cfg_ch) == i);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    jtframe_fraccen_ch #(
      .W     (W),
      .DEF_N (DEF_N[i*W +: W]),
      .DEF_M (DEF_M[i*W +: W])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .load    (load[i]),
      .ld_n    (cfg_n),
      .ld_m    (cfg_m),
      .pulse_c (pulse[i]),
      .err     (err[i])
    );
  end

  // Lock counter restarts on every accepted write and saturates at LOCKDLY.
  always_comb begin
    cnt_nx = cnt;
    if (accept) begin
      cnt_nx = '0;
    end else if (run && (cnt < LOCK_END)) begin
      cnt_nx = cnt + LCW'(1);
    end
  end

  assign lock_nx = (cnt_nx == LOCK_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      locked <= 1'b0;
      cen    <= '0;
    end else begin
      cnt    <= cnt_nx;
      locked <= lock_nx;
      cen    <= lock_nx ? pulse : '0;
    end
  end

endmodule

// File: tb/tb_jtframe_fraccen_bank.sv
// Scoreboard bench for jtframe_fraccen_bank (CH=3): a cycle model predicts
// cen/err/locked per edge, plus rate, latency and lock-sequence checks.
module tb_jtframe_fraccen_bank;

  localparam int unsigned CH = 3;
  localparam int unsigned W  = 10;
  localparam int unsigned LD = 16;

  typedef struct packed {
    logic [CH-1:0] cen;
    logic [CH-1:0] err;
    logic          locked;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_n;
  logic [W-1:0]  cfg_m;
  logic [CH-1:0] cen;
  logic [CH-1:0] err;
  logic          locked;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  int unsigned mn[CH];
  int unsigned mm[CH];
  int unsigned macc[CH];
  int unsigned msync;
  int unsigned mcnt;

  logic [CH-1:0] s_cen;
  logic [CH-1:0] s_err;
  logic          s_locked;

  jtframe_fraccen_bank #(
    .CH      (CH),
    .W       (W),
    .LOCKDLY (LD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cfg_we (cfg_we),
    .cfg_ch (cfg_ch),
    .cfg_n  (cfg_n),
    .cfg_m  (cfg_m),
    .cen    (cen),
    .err    (err),
    .locked (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ok_ratio(input int unsigned n, input int unsigned m);
    return (n != 0) && (m != 0) && (n <= m);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      mn[i] = 1; mm[i] = 2; macc[i] = 0;
    end
    msync = 0;
    mcnt  = 0;
  endtask

  task automatic model_step(input logic we, input logic [1:0] ch, input int unsigned n,
                            input int unsigned m, output exp_t e);
    logic          run;
    logic          acc_ok;
    logic [CH-1:0] pul;
    int unsigned   s;
    run    = (msync == 2);
    acc_ok = we && run && (int'(ch) < CH);
    pul    = '0;
    e      = '0;
    for (int i = 0; i < CH; i++) begin
      if (acc_ok && int'(ch) == i) begin
        mn[i] = n; mm[i] = m; macc[i] = 0;
      end else if (!ok_ratio(mn[i], mm[i])) begin
        macc[i] = 0;
      end else if (run) begin
        s = macc[i] + mn[i];
        if (s >= mm[i]) begin
          macc[i] = s - mm[i];
          pul[i]  = 1'b1;
        end else begin
          macc[i] = s;
        end
      end
      e.err[i] = !ok_ratio(mn[i], mm[i]);
    end
    if (acc_ok) mcnt = 0;
    else if (run && mcnt < LD) mcnt++;
    e.locked = (mcnt == LD);
    e.cen    = e.locked ? pul : '0;
    if (msync < 2) msync++;
  endtask

  // Called at a negedge: drive, predict, clock once, compare at the next negedge.
  task automatic drive_cycle(input logic we, input logic [1:0] ch, input logic [W-1:0] n,
                             input logic [W-1:0] m);
    exp_t e;
    cfg_we = we; cfg_ch = ch; cfg_n = n; cfg_m = m;
    model_step(we, ch, int'(n), int'(m), e);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    e = sb.pop_front();
    s_cen = cen; s_err = err; s_locked = locked;
    check("cycle", 32'({cen, err, locked}), 32'(e));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive_cycle(1'b0, 2'd0, '0, '0);
  endtask

  task automatic lock_latency(input string tag);
    int first;
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      drive_cycle(1'b0, 2'd0, '0, '0);
      if (s_locked) first = k;
    end
    check(tag, 32'(first), 32'(LD + 2));
  endtask

  task automatic wait_lock(input string tag);
    for (int k = 0; k < 40 && !s_locked; k++) drive_cycle(1'b0, 2'd0, '0, '0);
    check(tag, 32'(s_locked), 32'(1));
  endtask

  task automatic ch0_toggle(input string tag);
    int cnt;
    int same;
    logic prev;
    cnt = 0; same = 0; prev = s_cen[0];
    for (int k = 0; k < 20; k++) begin
      drive_cycle(1'b0, 2'd0, '0, '0);
      cnt += int'(s_cen[0]);
      if (s_cen[0] == prev) same++;
      prev = s_cen[0];
    end
    check({tag, "_pulses"}, 32'(cnt), 32'(10));
    check({tag, "_alternate"}, 32'(same), 32'(0));
    check({tag, "_err"}, 32'(s_err), 32'(0));
  endtask

  initial begin
    logic [63:0] pat;
    int cnt;
    int lowcnt;
    int cenlow;
    logic we;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_n = '0; cfg_m = '0;
    s_cen = '0; s_err = '0; s_locked = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cen", 32'(cen), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));

    rst_n = 1'b1;
    lock_latency("lock_latency");
    ch0_toggle("ch0");

    // ch1 at 3/8: 24 pulses in any 64-cycle window, period 8
    drive_cycle(1'b1, 2'd1, W'(3), W'(8));
    check("ch1_unlock", 32'(s_locked), 32'(0));
    wait_lock("ch1_relock");
    pat = '0;
    for (int k = 0; k < 64; k++) begin
      drive_cycle(1'b0, 2'd0, '0, '0);
      pat[k] = s_cen[1];
    end
    check("ch1_pulses", 32'($countones(pat)), 32'(24));
    cnt = 0;
    for (int k = 0; k < 56; k++) if (pat[k] != pat[k+8]) cnt++;
    check("ch1_period", 32'(cnt), 32'(0));

    // ch2 invalid then n == m
    drive_cycle(1'b1, 2'd2, W'(5), W'(4));
    check("ch2_err_set", 32'(s_err[2]), 32'(1));
    wait_lock("ch2_lock_bad");
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      drive_cycle(1'b0, 2'd0, '0, '0);
      cnt += int'(s_cen[2]);
    end
    check("ch2_no_pulse", 32'(cnt), 32'(0));
    drive_cycle(1'b1, 2'd2, W'(4), W'(4));
    check("ch2_err_clr", 32'(s_err[2]), 32'(0));
    wait_lock("ch2_lock_full");
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive_cycle(1'b0, 2'd0, '0, '0);
      cnt += int'(s_cen[2]);
    end
    check("ch2_full_rate", 32'(cnt), 32'(20));

    // writes on cycles 0, 3, 10: locked low for cycles 1..26, high at 27
    lowcnt = 0; cenlow = 0;
    for (int c = 0; c <= 26; c++) begin
      we = (c == 0) || (c == 3) || (c == 10);
      drive_cycle(we, 2'd0, W'(1), W'(2));
      if (!s_locked) begin
        lowcnt++;
        cenlow += $countones(s_cen);
      end
    end
    check("burst_low_cycles", 32'(lowcnt), 32'(26));
    check("burst_relock", 32'(s_locked), 32'(1));
    check("burst_cen_masked", 32'(cenlow), 32'(0));

    // out-of-range channel is ignored
    drive_cycle(1'b1, 2'd3, W'(7), W'(9));
    check("bad_ch_locked", 32'(s_locked), 32'(1));
    check("bad_ch_err", 32'(s_err), 32'(0));
    idle(6);

    // mid-run reset pulse
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_cen", 32'(cen), 32'(0));
    check("midrst_locked", 32'(locked), 32'(0));
    check("midrst_err", 32'(err), 32'(0));
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    lock_latency("relock_latency");
    ch0_toggle("ch0_after_rst");

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
